// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_e;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/auto-repeat FSM.
//
// state   | meaning
// IDLE    | debounced level is released, waiting for an accepted press
// PRESSED | press pulse emitted, timing the initial repeat delay
// REPEAT  | auto-repeating, one pulse every REPEAT_PERIOD cycles
module btn_channel #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit RAW_RELEASED    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic pulse
);
  import btn_pkg::*;

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          pulse_q, pulse_d;
  btn_state_e    state_q, state_d;

  logic pressed;
  logic rise;
  logic fall;

  // Synchroniser stays in raw polarity; the released value is its reset state.
  always_comb begin
    sync_d   = {sync_q[0], raw_in};
    pressed  = sync_q[1] ^ RAW_RELEASED;
    db_cnt_d = '0;
    level_d  = level_q;
    if (pressed != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    rise      = level_d & ~level_q;
    fall      = ~level_d & level_q;
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    pulse_d   = 1'b0;
    case (state_q)
      IDLE: begin
        rpt_cnt_d = '0;
        if (rise) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (REPEAT_DELAY == 0) begin
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RD_LAST) begin
          state_d   = REPEAT;
          pulse_d   = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RW'(1);
        end
      end
      REPEAT: begin
        // Release wins over a repeat falling due on the same edge.
        if (fall) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RP_LAST) begin
          pulse_d   = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {2{RAW_RELEASED}};
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      rpt_cnt_q <= rpt_cnt_d;
      pulse_q   <= pulse_d;
      state_q   <= state_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Two-button conditioner: polarity selection, two btn_channel instances, both_held.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s0_raw,
  input  logic s1_raw,
  output logic s0_level,
  output logic s1_level,
  output logic s0_pulse,
  output logic s1_pulse,
  output logic both_held
);
  import btn_pkg::*;

  localparam bit RAW_RELEASED = (ACTIVE_LOW != 0);

  logic both_held_q, both_held_d;

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .RAW_RELEASED   (RAW_RELEASED)
  ) u_ch0 (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_in(s0_raw),
    .level (s0_level),
    .pulse (s0_pulse)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .RAW_RELEASED   (RAW_RELEASED)
  ) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_in(s1_raw),
    .level (s1_level),
    .pulse (s1_pulse)
  );

  always_comb begin
    both_held_d = s0_level & s1_level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      both_held_q <= 1'b0;
    end else begin
      both_held_q <= both_held_d;
    end
  end

  assign both_held = both_held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic s0_raw = 1'b0;
  logic s1_raw = 1'b1;
  logic s0_level, s1_level, s0_pulse, s1_pulse, both_held;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_q0[$];
  int exp_q1[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_raw   (s0_raw),
    .s1_raw   (s1_raw),
    .s0_level (s0_level),
    .s1_level (s1_level),
    .s0_pulse (s0_pulse),
    .s1_pulse (s1_pulse),
    .both_held(both_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pulse monitor: each observed pulse must match the oldest expected edge.
  always @(negedge clk) begin
    if (s0_pulse) begin
      if (exp_q0.size() == 0) chk("s0_pulse_unexpected", cyc, -1);
      else chk("s0_pulse_cycle", cyc, exp_q0.pop_front());
    end else if (exp_q0.size() != 0 && exp_q0[0] < cyc) begin
      chk("s0_pulse_missed", cyc, exp_q0.pop_front());
    end
    if (s1_pulse) begin
      if (exp_q1.size() == 0) chk("s1_pulse_unexpected", cyc, -1);
      else chk("s1_pulse_cycle", cyc, exp_q1.pop_front());
    end else if (exp_q1.size() != 0 && exp_q1[0] < cyc) begin
      chk("s1_pulse_missed", cyc, exp_q1.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < t) chk("wait_cyc_timeout", cyc, t);
  endtask

  task automatic drain(input string tag);
    repeat (15) @(negedge clk);
    chk({tag, "_q0_empty"}, exp_q0.size(), 0);
    chk({tag, "_q1_empty"}, exp_q1.size(), 0);
  endtask

  initial begin
    int n, p, r, n2;

    // Reset held with s0 "pressed" on the raw pin.
    repeat (4) @(negedge clk);
    chk("rst_s0_level", s0_level, 0);
    chk("rst_s1_level", s1_level, 0);
    chk("rst_s0_pulse", s0_pulse, 0);
    chk("rst_s1_pulse", s1_pulse, 0);
    chk("rst_both_held", both_held, 0);

    s0_raw = 1'b1;
    s1_raw = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {s0_level, s1_level, s0_pulse, s1_pulse, both_held}, 0);
    end

    // Clean press and release.
    s0_raw = 1'b0;
    n = cyc + 1;
    exp_q0.push_back(n + 1 + DB);
    wait_cyc(n + DB);
    chk("press_level_early", s0_level, 0);
    wait_cyc(n + 1 + DB);
    chk("press_level", s0_level, 1);
    wait_cyc(n + 2 + DB);
    chk("press_pulse_one_cycle", s0_pulse, 0);
    s0_raw = 1'b1;
    r = cyc + 1;
    wait_cyc(r + DB);
    chk("release_level_early", s0_level, 1);
    wait_cyc(r + 1 + DB);
    chk("release_level", s0_level, 0);
    drain("clean");

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 10; i++) begin
      s0_raw = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("bounce_level", s0_level, 0);
      end
      s0_raw = 1'b1;
      repeat (2) begin
        @(negedge clk);
        chk("bounce_level", s0_level, 0);
      end
    end
    drain("bounce");
    chk("bounce_level_final", s0_level, 0);

    // Auto-repeat: press pulse, then delay RD, then every RP.
    s0_raw = 1'b0;
    n = cyc + 1;
    p = n + 1 + DB;
    exp_q0.push_back(p);
    for (int k = p + RD; k <= p + 37; k += RP) exp_q0.push_back(k);
    wait_cyc(p + 34);
    s0_raw = 1'b1;
    wait_cyc(p + 39);
    chk("repeat_level_held", s0_level, 1);
    wait_cyc(p + 40);
    chk("repeat_level_released", s0_level, 0);
    drain("repeat");

    // Simultaneous presses.
    s0_raw = 1'b0;
    s1_raw = 1'b0;
    n = cyc + 1;
    exp_q0.push_back(n + 1 + DB);
    exp_q1.push_back(n + 1 + DB);
    wait_cyc(n + 1 + DB);
    chk("simul_s0_level", s0_level, 1);
    chk("simul_s1_level", s1_level, 1);
    chk("simul_both_lag", both_held, 0);
    wait_cyc(n + 2 + DB);
    chk("simul_both_held", both_held, 1);
    s0_raw = 1'b1;
    s1_raw = 1'b1;
    r = cyc + 1;
    wait_cyc(r + 1 + DB);
    chk("simul_both_still", both_held, 1);
    wait_cyc(r + 2 + DB);
    chk("simul_both_dropped", both_held, 0);
    drain("simul");

    // Reset asserted while repeating.
    s0_raw = 1'b0;
    n = cyc + 1;
    p = n + 1 + DB;
    exp_q0.push_back(p);
    exp_q0.push_back(p + RD);
    wait_cyc(p + RD + RP - 1);
    @(posedge clk);
    #1;
    chk("midrep_pulse_before_rst", s0_pulse, 1);
    rst_n = 1'b0;
    #1;
    chk("midrep_pulse_async", s0_pulse, 0);
    chk("midrep_level_async", s0_level, 0);
    repeat (3) @(negedge clk);
    chk("midrep_rst_level", s0_level, 0);
    rst_n = 1'b1;
    n2 = cyc + 1;
    exp_q0.push_back(n2 + 1 + DB);
    wait_cyc(n2 + DB);
    chk("midrep_fresh_early", s0_level, 0);
    wait_cyc(n2 + 1 + DB);
    chk("midrep_fresh_level", s0_level, 1);
    s0_raw = 1'b1;
    drain("midrep");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
